// File: rtl/mmio_dma.sv
// Byte-wide MMIO bus-master copy engine: one read then one write per byte,
// stalled by grant, with abort that never drops a byte already read.
module mmio_dma #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [14:0] src,
  input  logic [14:0] dst,
  input  logic [8:0]  len,
  input  logic        src_inc,
  input  logic        dst_inc,
  input  logic        grant,
  output logic        m_re,
  output logic        m_we,
  output logic [14:0] m_addr,
  output logic [7:0]  m_data_write,
  input  logic [7:0]  m_data_read,
  output logic        busy,
  output logic        done,
  output logic [8:0]  remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [14:0] src_ptr, src_ptr_nxt;
  logic [14:0] dst_ptr, dst_ptr_nxt;
  logic        src_step, src_step_nxt;
  logic        dst_step, dst_step_nxt;
  logic [1:0]  wcnt, wcnt_nxt;
  logic        abort_pend, abort_pend_nxt;
  logic        m_re_nxt, m_we_nxt, busy_nxt, done_nxt;
  logic [14:0] m_addr_nxt;
  logic [7:0]  m_data_write_nxt;
  logic [8:0]  remaining_nxt;

  logic [14:0] src_adv, dst_adv;
  logic [8:0]  rem_dec;
  logic        abort_now;

  // 15-bit adds wrap 0x7FFF -> 0x0000 by construction.
  assign src_adv   = src_ptr + 15'(src_step);
  assign dst_adv   = dst_ptr + 15'(dst_step);
  assign rem_dec   = remaining - 9'd1;
  assign abort_now = abort | abort_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      src_step     <= 1'b0;
      dst_step     <= 1'b0;
      wcnt         <= '0;
      abort_pend   <= 1'b0;
      m_re         <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_data_write <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      remaining    <= '0;
    end else begin
      state        <= state_nxt;
      src_ptr      <= src_ptr_nxt;
      dst_ptr      <= dst_ptr_nxt;
      src_step     <= src_step_nxt;
      dst_step     <= dst_step_nxt;
      wcnt         <= wcnt_nxt;
      abort_pend   <= abort_pend_nxt;
      m_re         <= m_re_nxt;
      m_we         <= m_we_nxt;
      m_addr       <= m_addr_nxt;
      m_data_write <= m_data_write_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      remaining    <= remaining_nxt;
    end
  end

  // Strobes are registered, so each one is decided from grant sampled at the
  // edge that starts its cycle; a READ/WRITE cycle without a strobe is a stall.
  always_comb begin
    state_nxt        = state;
    src_ptr_nxt      = src_ptr;
    dst_ptr_nxt      = dst_ptr;
    src_step_nxt     = src_step;
    dst_step_nxt     = dst_step;
    wcnt_nxt         = wcnt;
    abort_pend_nxt   = abort_pend;
    m_re_nxt         = 1'b0;
    m_we_nxt         = 1'b0;
    m_addr_nxt       = m_addr;
    m_data_write_nxt = m_data_write;
    busy_nxt         = busy;
    done_nxt         = 1'b0;
    remaining_nxt    = remaining;

    case (state)
      S_IDLE: begin
        abort_pend_nxt = 1'b0;
        if (start) begin
          src_ptr_nxt   = src;
          dst_ptr_nxt   = dst;
          src_step_nxt  = src_inc;
          dst_step_nxt  = dst_inc;
          remaining_nxt = len;
          if (len != 9'd0) begin
            state_nxt = S_READ;
            busy_nxt  = 1'b1;
            if (grant) begin
              m_re_nxt   = 1'b1;
              m_addr_nxt = src;
            end
          end else begin
            state_nxt = S_FIN;
            done_nxt  = 1'b1;
          end
        end
      end

      S_READ: begin
        if (m_re) begin
          // The read is on the bus; its byte must be written even if aborted.
          state_nxt = S_WAIT;
          wcnt_nxt  = WAIT_LAST;
          if (abort) abort_pend_nxt = 1'b1;
        end else if (abort_now) begin
          state_nxt = S_FIN;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else if (grant) begin
          m_re_nxt   = 1'b1;
          m_addr_nxt = src_ptr;
        end
      end

      S_WAIT: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (wcnt == 2'd0) begin
          m_data_write_nxt = m_data_read;
          state_nxt        = S_WRITE;
          if (grant) begin
            m_we_nxt   = 1'b1;
            m_addr_nxt = dst_ptr;
          end
        end else begin
          wcnt_nxt = wcnt - 2'd1;
        end
      end

      S_WRITE: begin
        if (m_we) begin
          remaining_nxt = rem_dec;
          src_ptr_nxt   = src_adv;
          dst_ptr_nxt   = dst_adv;
          if (rem_dec == 9'd0 || abort_now) begin
            state_nxt = S_FIN;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = S_READ;
            if (grant) begin
              m_re_nxt   = 1'b1;
              m_addr_nxt = src_adv;
            end
          end
        end else begin
          if (abort) abort_pend_nxt = 1'b1;
          if (grant) begin
            m_we_nxt   = 1'b1;
            m_addr_nxt = dst_ptr;
          end
        end
      end

      S_FIN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_dma.sv
// Scoreboard bench for mmio_dma: stimulus queues expected bus reads, writes and
// done events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mmio_dma;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [14:0] src, dst;
  logic [8:0]  len;
  logic        src_inc, dst_inc, grant;
  logic        m_re, m_we;
  logic [14:0] m_addr;
  logic [7:0]  m_data_write, m_data_read;
  logic        busy, done;
  logic [8:0]  remaining;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { logic [14:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [8:0] rem; } dn_t;

  logic [14:0] rd_q[$];
  wr_t         wr_q[$];
  dn_t         dn_q[$];

  mmio_dma #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src(src), .dst(dst), .len(len), .src_inc(src_inc), .dst_inc(dst_inc),
    .grant(grant), .m_re(m_re), .m_we(m_we), .m_addr(m_addr),
    .m_data_write(m_data_write), .m_data_read(m_data_read),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ {a[14:8], 1'b1};
  endfunction

  // Bus returns mem[a] one cycle after m_re; junk otherwise so late capture shows.
  always @(posedge clk) m_data_read <= m_re ? pat(m_addr) : 8'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [14:0] ra;
    wr_t w;
    dn_t d;
    if (!reset) begin
      if (m_re || m_we) chk("strobe_excl", 32'(m_re && m_we), 32'd0);
      if (m_re) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: m_re at %h, expected none", m_addr);
        end else begin
          ra = rd_q.pop_front();
          if (m_addr !== ra) begin
            errors++;
            $display("FAIL rd_addr: got %h expected %h", m_addr, ra);
          end
        end
      end
      if (m_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: m_we at %h data %h, expected none", m_addr, m_data_write);
        end else begin
          w = wr_q.pop_front();
          if (m_addr !== w.addr || m_data_write !== w.data) begin
            errors++;
            $display("FAIL wr: got %h/%h expected %h/%h", m_addr, m_data_write, w.addr, w.data);
          end
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: done at cycle %0d", cyc);
        end else begin
          d = dn_q.pop_front();
          chk("done_rem", 32'(remaining), 32'(d.rem));
          chk("done_busy", 32'(busy), 32'd0);
          if (d.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(d.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [14:0] s, d, input logic [8:0] n,
                             input logic si, di, output int c);
    src = s; dst = d; len = n; src_inc = si; dst_inc = di;
    start = 1'b1;
    c = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_copy(input logic [14:0] s, d, input int n, input logic si, di);
    logic [14:0] sa, da;
    wr_t w;
    sa = s; da = d;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(sa);
      w.addr = da; w.data = pat(sa);
      wr_q.push_back(w);
      if (si) sa = sa + 15'd1;
      if (di) da = da + 15'd1;
    end
  endtask

  task automatic push_done(input int c, input logic [8:0] r);
    dn_t d;
    d.cyc = c; d.rem = r;
    dn_q.push_back(d);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 80 && (rd_q.size() != 0 || wr_q.size() != 0 || dn_q.size() != 0)) begin
      tick();
      k++;
    end
    if (rd_q.size() != 0 || wr_q.size() != 0 || dn_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: pending rd=%0d wr=%0d done=%0d, required 0",
               name, rd_q.size(), wr_q.size(), dn_q.size());
      rd_q.delete(); wr_q.delete(); dn_q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; abort = 1'b0; grant = 1'b1;
    src = '0; dst = '0; len = '0; src_inc = 1'b0; dst_inc = 1'b0;
    #1;
    chk("rst_m_re", 32'(m_re), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_data_write", 32'(m_data_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic copy: 4 bytes, done 13 cycles after start.
    pulse_start(15'h0010, 15'h0300, 9'd4, 1'b1, 1'b1, c);
    push_copy(15'h0010, 15'h0300, 4, 1'b1, 1'b1);
    push_done(c + 13, 9'd0);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_rem_start", 32'(remaining), 32'd4);
    chk("basic_first_re", 32'(m_re), 32'd1);
    drain("basic");

    // Fixed destination.
    pulse_start(15'h0020, 15'h0301, 9'd3, 1'b1, 1'b0, c);
    push_copy(15'h0020, 15'h0301, 3, 1'b1, 1'b0);
    push_done(c + 10, 9'd0);
    drain("fixed_dst");

    // Grant low for 5 cycles starting with the start cycle: READ stalls 5 cycles.
    grant = 1'b0;
    pulse_start(15'h0040, 15'h0500, 9'd2, 1'b1, 1'b1, c);
    push_copy(15'h0040, 15'h0500, 2, 1'b1, 1'b1);
    push_done(c + 7 + 5, 9'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("stall_no_re", 32'(m_re), 32'd0);
      tick();
    end
    grant = 1'b1;
    chk("stall_no_re", 32'(m_re), 32'd0);
    tick();
    chk("stall_re_resume", 32'(m_re), 32'd1);
    drain("grant_read");

    // Grant low during WAIT: captured byte must still be the one read.
    pulse_start(15'h0050, 15'h0600, 9'd2, 1'b1, 1'b1, c);
    push_copy(15'h0050, 15'h0600, 2, 1'b1, 1'b1);
    push_done(-1, 9'd0);
    tick();
    grant = 1'b0;
    tick();
    grant = 1'b1;
    drain("grant_wait");

    // Zero length: done next cycle, no bus activity.
    pulse_start(15'h0070, 15'h0700, 9'd0, 1'b1, 1'b1, c);
    push_done(c + 1, 9'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    drain("zero_len");

    // Source address wrap.
    pulse_start(15'h7FFE, 15'h0100, 9'd3, 1'b1, 1'b1, c);
    push_copy(15'h7FFE, 15'h0100, 3, 1'b1, 1'b1);
    push_done(c + 10, 9'd0);
    drain("wrap");

    // Abort in WAIT of byte 3 (cycle c+8); a start while busy is ignored.
    pulse_start(15'h0200, 15'h0400, 9'd10, 1'b1, 1'b1, c);
    push_copy(15'h0200, 15'h0400, 3, 1'b1, 1'b1);
    push_done(c + 10, 9'd7);
    tick(); tick(); tick();
    src = 15'h1234; dst = 15'h2345; len = 9'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_rem", 32'(remaining), 32'd9);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    drain("abort");
    chk("abort_rem_hold", 32'(remaining), 32'd7);

    // Reset asserted mid-WRITE of byte 1 (cycle c+3) clears outputs at once.
    pulse_start(15'h0010, 15'h0700, 9'd4, 1'b1, 1'b1, c);
    rd_q.push_back(15'h0010);
    tick(); tick();
    chk("pre_reset_we", 32'(m_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(m_we), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_addr", 32'(m_addr), 32'd0);
    chk("async_rst_rem", 32'(remaining), 32'd0);
    tick();
    chk("rst_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    chk("rst_rd_drained", 32'(rd_q.size()), 32'd0);
    rd_q.delete();
    tick();
    pulse_start(15'h0060, 15'h0720, 9'd2, 1'b1, 1'b1, c);
    push_copy(15'h0060, 15'h0720, 2, 1'b1, 1'b1);
    push_done(c + 7, 9'd0);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_dma.md
# mmio_dma

Bus-master copy engine that drives the same byte-wide MMIO bus the CPU uses (re/we/15-bit addr/8-bit read and write data). It moves a block of bytes from a source address range to a destination address range, one read then one write per byte, for example to fill the vgaterm or sound registers from RAM without CPU involvement. It sits beside the CPU on the peripheral bus. An external arbiter grants it the bus, and its outputs are muxed onto re/we/addr/data_write while `grant` is high.

## Interface
- RD_LAT, 1: cycles from the `m_re` cycle to valid `m_data_read`. Legal range is 1–4. The MMIO block latches its read data, so 1 is correct for it.
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches src/dst/len/src_inc/dst_inc when idle
- abort  in  1  terminates the transfer at the next safe point
- src  in  15  source start address
- dst  in  15  destination start address
- len  in  9  byte count, 0–256; 0 means no transfer
- src_inc  in  1  1 = increment source address per byte; 0 = fixed (peripheral FIFO)
- dst_inc  in  1  same for destination
- grant  in  1  bus granted to this master; 0 stalls the engine
- m_re  out  1  bus read strobe
- m_we  out  1  bus write strobe
- m_addr  out  15  bus address
- m_data_write  out  8  write data
- m_data_read  in  8  read data returned by the bus
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion or abort
- remaining  out  9  bytes not yet written

## Operation
- Reset (asynchronous) drives these values: state IDLE; m_re=0, m_we=0, m_addr=0, m_data_write=0, busy=0, done=0, remaining=0; internal address and data registers are 0.
- States:
  - IDLE
  - READ: m_re=1, m_addr=src_ptr, for exactly one cycle.
  - WAIT: RD_LAT cycles; m_re=0.
  - WRITE: m_we=1, m_addr=dst_ptr, m_data_write=captured byte, for exactly one cycle.
  - FIN: done=1.
- IDLE→READ when start=1 and len≠0. Latch pointers, set remaining=len, and set busy=1.
- IDLE→FIN when start=1 and len=0. No bus activity occurs; done pulses and busy stays 0.
- start while not IDLE is ignored. Latched parameters do not change.
- WAIT: the byte is captured from m_data_read on the last WAIT cycle, i.e. the RD_LAT-th cycle after READ.
- WAIT→WRITE always follows capture.
- WRITE: decrement remaining. Advance src_ptr/dst_ptr by 1 if the corresponding _inc is set; pointers wrap 0x7FFF→0x0000 (15-bit modulo).
  - If remaining becomes 0, go to FIN.
  - Otherwise go to READ.
- FIN→IDLE next cycle; busy=0 in FIN.
- grant=0: READ and WRITE do not assert their strobe and hold state until grant=1. An interrupted read is never half-issued. WAIT is not stalled by grant, since data is already in flight.
- m_addr holds its last value when no strobe is active. m_re and m_we are never high together.
- abort while busy completes any WAIT→WRITE already in progress, so a read byte is never dropped, then goes to FIN. remaining reports the uncopied bytes. abort in READ (stalled or not) goes to FIN without a read strobe. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start wins.

## Timing
- Per byte with grant=1: 2+RD_LAT cycles (READ, RD_LAT×WAIT, WRITE). The default is 3 cycles per byte.
- The first m_re occurs in the cycle after the start pulse.
- done occurs in the cycle after the final WRITE.
- Total for N bytes: start → done = N×(2+RD_LAT)+1 cycles, plus any grant-stall cycles.
- All outputs are registered; there is no combinational path from inputs to m_* outputs.
- Reset asserted mid-transfer returns all outputs to their reset values immediately (asynchronously). No done pulse is emitted.

## Test plan
- **Basic copy.** Bus model returns mem[a]. Inputs: src=0x0010, dst=0x0300, len=4, both inc, RD_LAT=1.
  - Required: m_re at 0x10, 0x11, 0x12, 0x13 and m_we at 0x300–0x303 with matching data.
  - Required: done 13 cycles after start, remaining=0.
- **Fixed destination.** Inputs: dst_inc=0, dst=0x0301, len=3.
  - Required: three writes all to 0x0301, in source order.
- **Grant stall.**
  - Drop grant for 5 cycles while in READ. Required: no m_re during the stall, and total latency grows by exactly 5.
  - Drop grant during WAIT. Required: the capture is unaffected.
- **Zero and wrap.**
  - len=0. Required: done one cycle after start, with no m_re or m_we.
  - src=0x7FFE, len=3, inc. Required: reads at 0x7FFE, 0x7FFF, 0x0000.
- **Abort.** Inputs: len=10; assert abort in the WAIT of byte 3.
  - Required: byte 3 is written, then done pulses and remaining=7.
  - Required: a start during busy is ignored.
- **Reset mid-transfer.** Assert reset during WRITE.
  - Required: m_we=0 and busy=0 immediately (before the next edge).
  - Required: a new start after release copies correctly from the new src.
